core_if: RTL

Instruction fetch stage of the xRV32I core. It owns the program counter and issues word fetches to instruction memory over a valid/ready request channel. Returned instructions are buffered with their addresses in a small prefetch FIFO, which presents them to core_if_id under a valid/ready handshake. A redirect from the execute stage flushes the wrong path and discards responses already in flight.

---
 rtl/core_if_pkg.sv | 20 ++
 rtl/core_if_fifo.sv | 71 +++++++
 rtl/core_if.sv | 130 +++++++++++++
 3 files changed

// File: rtl/core_if_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Entry layout of the prefetch FIFO plus the canonical NOP and reset address.
package core_if_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] INST_NOP       = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] CPU_RESET_ADDR = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/core_if_fifo.sv
// Synchronous FIFO with flush, used both for the prefetch buffer and for the
// in-flight address queue. Head is read straight from the storage registers.
module core_if_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);

  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && count_q == FULL_COUNT));

  underflow_a: assert property (@(posedge clk) disable iff (rst)
    !(pop && !flush && count_q == '0));

endmodule

// File: rtl/core_if.sv
// Instruction fetch stage: owns the PC, issues word fetches under a credit
// limit, buffers responses with their addresses and handles redirects.
module core_if
  import core_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = CPU_RESET_ADDR,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        inst_valid_out,
  input  logic        inst_ready_in,
  output logic [31:0] inst_out,
  output logic [31:0] inst_addr_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          req_fire;
  logic          credit_ok;
  logic [CW:0]   occupancy;

  logic          fifo_push, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_in, fifo_head;

  logic          aq_pop;
  logic [CW-1:0] aq_count;
  logic          aq_empty;
  logic [31:0]   aq_head;

  // Outstanding requests are exactly the occupancy of the in-flight address
  // queue, which is never flushed so dropped responses still retire from it.
  assign occupancy = {1'b0, aq_count} + {1'b0, fifo_count};
  assign credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);

  assign imem_req_valid = !rst && !jump_en && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign aq_pop    = imem_rsp_valid && !aq_empty;
  assign fifo_push = imem_rsp_valid && (drop_q == '0) && !jump_en;
  assign fifo_pop  = inst_valid_out && inst_ready_in;
  assign fifo_in   = '{addr: aq_head, inst: imem_rsp_data};

  always_comb begin
    pc_d = pc_q;
    if (jump_en) begin
      pc_d = word_align(jump_addr);
    end else if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Every request still in flight at a redirect belongs to the old path; the
  // dropped ones are already part of that count, so it replaces drop_q.
  always_comb begin
    drop_d = drop_q;
    if (jump_en) begin
      drop_d = aq_count - {{(CW-1){1'b0}}, imem_rsp_valid};
    end else if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= word_align(RESET_PC);
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  core_if_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .flush     (jump_en),
    .count     (fifo_count),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  core_if_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_addr_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (aq_pop),
    .flush     (1'b0),
    .count     (aq_count),
    .head      (aq_head),
    .empty     (aq_empty)
  );

  assign inst_valid_out = !fifo_empty;
  assign inst_out       = fifo_empty ? INST_NOP : fifo_head.inst;
  assign inst_addr_out  = fifo_empty ? 32'h0 : fifo_head.addr;

  credit_a: assert property (@(posedge clk) disable iff (rst)
    occupancy <= (CW+1)'(FIFO_DEPTH));

  drop_a: assert property (@(posedge clk) disable iff (rst)
    drop_q <= aq_count);

  rsp_a: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> !aq_empty);

endmodule
